// File: rtl/rv32_pipe_pkg.sv
// rtl/rv32_pipe_pkg.sv - shared types and constants for the RV32 pipeline front end
package rv32_pipe_pkg;

    // Fetch unit sequencing
    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2,
        HALT = 2'd3
    } fetch_state_t;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Branch target source, shared with ID
    localparam logic PC_RELATIVE = 1'b0;
    localparam logic REG_OFFSET  = 1'b1;

    // Instruction fetch targets must be word aligned (no compressed ISA)
    function automatic logic is_word_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/if_fetch_outreg.sv
// rtl/if_fetch_outreg.sv - IF/ID output register with load, flush and hold controls
module if_fetch_outreg
    import rv32_pipe_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_load,
    input  logic        i_flush,
    input  logic        i_hold,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_instr,
    output logic        o_valid,
    output logic [31:0] o_pc,
    output logic [31:0] o_instr
);

    logic        r_valid;
    logic [31:0] r_pc;
    logic [31:0] r_instr;

    // Flush beats load; otherwise a delivered instruction lives one cycle unless held
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_valid <= 1'b0;
            r_pc    <= 32'h0000_0000;
            r_instr <= NOP_INSTR;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_pc    <= i_pc;
            r_instr <= i_instr;
        end else if (!i_hold) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_pc    = r_pc;
    assign o_instr = r_instr;

endmodule

// File: rtl/if_pc_fetch.sv
// rtl/if_pc_fetch.sv - IF stage PC, single-outstanding instruction fetch and redirect handling
module if_pc_fetch
    import rv32_pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        Branch_taken,
    input  logic [31:0] Branch_dest,
    input  logic        Stall,
    output logic        IMEM_req,
    output logic [31:0] IMEM_addr,
    input  logic        IMEM_gnt,
    input  logic        IMEM_rvalid,
    input  logic [31:0] IMEM_rdata,
    output logic        IF_valid,
    output logic [31:0] IF_PC,
    output logic [31:0] IF_instr,
    output logic        Misaligned_exc,
    output logic [31:0] Misaligned_addr
);

    localparam logic [31:0] STEP = 32'(PC_STEP);

    fetch_state_t r_state;
    logic [31:0]  r_pc;
    logic         r_req;
    logic         r_kill;
    logic         r_halt_pend;
    logic [31:0]  r_fetch_addr;
    logic         r_exc;
    logic [31:0]  r_maddr;

    logic w_gnt;
    logic w_redir_ok;
    logic w_redir_bad;
    logic w_load;

    // Stall withdraws a pending request immediately so no new fetch is accepted
    assign IMEM_req    = r_req & ~Stall;
    assign IMEM_addr   = r_pc;
    assign w_gnt       = IMEM_req & IMEM_gnt;
    assign w_redir_ok  = Branch_taken & is_word_aligned(Branch_dest);
    assign w_redir_bad = Branch_taken & ~is_word_aligned(Branch_dest);
    assign w_load      = (r_state == WAIT) & IMEM_rvalid & ~r_kill & ~Branch_taken;

    // Fetch sequencer: PC, request, kill of wrong-path responses, misalign trap
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= REQ;
            r_pc         <= RESET_PC;
            r_req        <= 1'b0;
            r_kill       <= 1'b0;
            r_halt_pend  <= 1'b0;
            r_fetch_addr <= 32'h0000_0000;
            r_exc        <= 1'b0;
            r_maddr      <= 32'h0000_0000;
        end else begin
            r_req <= 1'b0;
            r_exc <= w_redir_bad;
            if (w_redir_bad) begin
                r_maddr <= Branch_dest;
            end
            if (w_gnt) begin
                r_fetch_addr <= r_pc;
            end
            case (r_state)
                REQ: begin
                    if (w_redir_ok) begin
                        r_pc        <= Branch_dest;
                        r_halt_pend <= 1'b0;
                        if (w_gnt) begin
                            r_kill  <= 1'b1;
                            r_state <= WAIT;
                        end else begin
                            r_req <= 1'b1;
                        end
                    end else if (w_redir_bad) begin
                        if (w_gnt) begin
                            r_kill      <= 1'b1;
                            r_halt_pend <= 1'b1;
                            r_state     <= WAIT;
                        end else begin
                            r_state <= HALT;
                        end
                    end else if (w_gnt) begin
                        r_pc    <= r_pc + STEP;
                        r_state <= WAIT;
                    end else begin
                        r_req <= 1'b1;
                    end
                end
                WAIT: begin
                    if (w_redir_ok) begin
                        r_pc        <= Branch_dest;
                        r_halt_pend <= 1'b0;
                        if (IMEM_rvalid) begin
                            r_kill  <= 1'b0;
                            r_state <= REQ;
                            r_req   <= 1'b1;
                        end else begin
                            r_kill <= 1'b1;
                        end
                    end else if (w_redir_bad) begin
                        if (IMEM_rvalid) begin
                            r_kill      <= 1'b0;
                            r_halt_pend <= 1'b0;
                            r_state     <= HALT;
                        end else begin
                            r_kill      <= 1'b1;
                            r_halt_pend <= 1'b1;
                        end
                    end else if (IMEM_rvalid) begin
                        if (r_kill) begin
                            r_kill <= 1'b0;
                            if (r_halt_pend) begin
                                r_halt_pend <= 1'b0;
                                r_state     <= HALT;
                            end else begin
                                r_state <= REQ;
                                r_req   <= 1'b1;
                            end
                        end else if (Stall) begin
                            r_state <= HOLD;
                        end else begin
                            r_state <= REQ;
                            r_req   <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (w_redir_ok) begin
                        r_pc    <= Branch_dest;
                        r_state <= REQ;
                        r_req   <= 1'b1;
                    end else if (w_redir_bad) begin
                        r_state <= HALT;
                    end else if (!Stall) begin
                        r_state <= REQ;
                        r_req   <= 1'b1;
                    end
                end
                HALT: begin
                    if (w_redir_ok) begin
                        r_pc    <= Branch_dest;
                        r_state <= REQ;
                        r_req   <= 1'b1;
                    end
                end
                default: begin
                    r_state <= REQ;
                end
            endcase
        end
    end

    if_fetch_outreg u_outreg (
        .clk     (clk),
        .resetn  (resetn),
        .i_load  (w_load),
        .i_flush (Branch_taken),
        .i_hold  (Stall),
        .i_pc    (r_fetch_addr),
        .i_instr (IMEM_rdata),
        .o_valid (IF_valid),
        .o_pc    (IF_PC),
        .o_instr (IF_instr)
    );

    assign Misaligned_exc  = r_exc;
    assign Misaligned_addr = r_maddr;

endmodule

// File: tb/tb_if_pc_fetch.sv
// tb/tb_if_pc_fetch.sv - directed self-checking bench for if_pc_fetch
module tb_if_pc_fetch;

    logic        clk = 1'b0;
    logic        resetn;
    logic        Branch_taken;
    logic [31:0] Branch_dest;
    logic        Stall;
    logic        IMEM_req;
    logic [31:0] IMEM_addr;
    logic        IMEM_gnt;
    logic        IMEM_rvalid;
    logic [31:0] IMEM_rdata;
    logic        IF_valid;
    logic [31:0] IF_PC;
    logic [31:0] IF_instr;
    logic        Misaligned_exc;
    logic [31:0] Misaligned_addr;

    logic        gnt_en;
    int          lat;
    logic        m_pend;
    logic [31:0] m_addr;
    int          m_cnt;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    assign IMEM_gnt = IMEM_req & gnt_en;

    if_pc_fetch dut (
        .clk             (clk),
        .resetn          (resetn),
        .Branch_taken    (Branch_taken),
        .Branch_dest     (Branch_dest),
        .Stall           (Stall),
        .IMEM_req        (IMEM_req),
        .IMEM_addr       (IMEM_addr),
        .IMEM_gnt        (IMEM_gnt),
        .IMEM_rvalid     (IMEM_rvalid),
        .IMEM_rdata      (IMEM_rdata),
        .IF_valid        (IF_valid),
        .IF_PC           (IF_PC),
        .IF_instr        (IF_instr),
        .Misaligned_exc  (Misaligned_exc),
        .Misaligned_addr (Misaligned_addr)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A00_0013;
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // One clock; memory answers each accepted request after lat cycles
    task automatic tick();
        logic        acc;
        logic        rv;
        logic [31:0] a;
        #1;
        acc = IMEM_req & IMEM_gnt;
        rv  = IMEM_rvalid;
        a   = IMEM_addr;
        @(posedge clk);
        #1;
        if (rv) m_pend = 1'b0;
        if (acc) begin
            m_pend = 1'b1;
            m_addr = a;
            m_cnt  = lat;
        end
        if (m_pend && m_cnt <= 1) begin
            IMEM_rvalid = 1'b1;
            IMEM_rdata  = mem_word(m_addr);
        end else begin
            if (m_pend) m_cnt--;
            IMEM_rvalid = 1'b0;
            IMEM_rdata  = 32'hDEAD_BEEF;
        end
    endtask

    task automatic expect_fetch(input string tag, input logic [31:0] pc);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!IF_valid && n < 20);
        chk({tag, "_valid"}, {31'd0, IF_valid}, 32'd1);
        chk({tag, "_pc"}, IF_PC, pc);
        chk({tag, "_instr"}, IF_instr, mem_word(pc));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req"}, {31'd0, IMEM_req}, 32'd0);
        chk({tag, "_valid"}, {31'd0, IF_valid}, 32'd0);
        chk({tag, "_pc"}, IF_PC, 32'h0000_0000);
        chk({tag, "_instr"}, IF_instr, 32'h0000_0013);
        chk({tag, "_exc"}, {31'd0, Misaligned_exc}, 32'd0);
        chk({tag, "_maddr"}, Misaligned_addr, 32'h0000_0000);
    endtask

    initial begin
        resetn       = 1'b0;
        Stall        = 1'b0;
        Branch_taken = 1'b0;
        Branch_dest  = 32'h0;
        IMEM_rvalid  = 1'b0;
        IMEM_rdata   = 32'h0;
        gnt_en       = 1'b1;
        lat          = 1;
        m_pend       = 1'b0;
        m_addr       = 32'h0;
        m_cnt        = 0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("rst");

        // 1: sequential fetch from reset
        resetn = 1'b1;
        tick();
        chk("t1_req0", {31'd0, IMEM_req}, 32'd1);
        chk("t1_addr0", IMEM_addr, 32'h0);
        expect_fetch("t1_f0", 32'h0);
        chk("t1_addr4", IMEM_addr, 32'h4);
        expect_fetch("t1_f4", 32'h4);
        expect_fetch("t1_f8", 32'h8);

        // 2: stall freezes outputs and suppresses requests
        Stall = 1'b1;
        #1;
        chk("t2_req_off", {31'd0, IMEM_req}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t2_valid", {31'd0, IF_valid}, 32'd1);
            chk("t2_pc", IF_PC, 32'h8);
            chk("t2_noreq", {31'd0, IMEM_req}, 32'd0);
        end
        Stall = 1'b0;
        #1;
        chk("t2_resume_addr", IMEM_addr, 32'hC);
        expect_fetch("t2_fC", 32'hC);

        // 3: redirect while waiting, late response dropped
        lat = 2;
        tick();
        chk("t3_wait_noreq", {31'd0, IMEM_req}, 32'd0);
        Branch_taken = 1'b1;
        Branch_dest  = 32'h100;
        tick();
        Branch_taken = 1'b0;
        chk("t3_still_wait", {31'd0, IMEM_req}, 32'd0);
        tick();
        chk("t3_req", {31'd0, IMEM_req}, 32'd1);
        chk("t3_addr", IMEM_addr, 32'h100);
        chk("t3_dropped", {31'd0, IF_valid}, 32'd0);
        lat = 1;
        expect_fetch("t3_f100", 32'h100);

        // 4: redirect wins over stall
        Branch_taken = 1'b1;
        Branch_dest  = 32'h40;
        Stall        = 1'b1;
        tick();
        Branch_taken = 1'b0;
        Stall        = 1'b0;
        #1;
        chk("t4_flush", {31'd0, IF_valid}, 32'd0);
        chk("t4_req", {31'd0, IMEM_req}, 32'd1);
        chk("t4_addr", IMEM_addr, 32'h40);
        expect_fetch("t4_f40", 32'h40);

        // 5: misaligned redirect traps and halts, aligned redirect resumes
        Branch_taken = 1'b1;
        Branch_dest  = 32'h102;
        tick();
        Branch_taken = 1'b0;
        chk("t5_exc", {31'd0, Misaligned_exc}, 32'd1);
        chk("t5_maddr", Misaligned_addr, 32'h102);
        chk("t5_flush", {31'd0, IF_valid}, 32'd0);
        chk("t5_noreq", {31'd0, IMEM_req}, 32'd0);
        tick();
        chk("t5_exc_pulse", {31'd0, Misaligned_exc}, 32'd0);
        chk("t5_maddr_hold", Misaligned_addr, 32'h102);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5_halt_req", {31'd0, IMEM_req}, 32'd0);
            chk("t5_halt_valid", {31'd0, IF_valid}, 32'd0);
        end
        Branch_taken = 1'b1;
        Branch_dest  = 32'h200;
        tick();
        Branch_taken = 1'b0;
        chk("t5_resume_req", {31'd0, IMEM_req}, 32'd1);
        chk("t5_resume_addr", IMEM_addr, 32'h200);
        expect_fetch("t5_f200", 32'h200);

        // 6: PC wrap, then asynchronous reset during an outstanding fetch
        Branch_taken = 1'b1;
        Branch_dest  = 32'hFFFF_FFFC;
        tick();
        Branch_taken = 1'b0;
        expect_fetch("t6_ffc", 32'hFFFF_FFFC);
        chk("t6_wrap_addr", IMEM_addr, 32'h0);
        lat = 3;
        tick();
        chk("t6_in_wait", {31'd0, IMEM_req}, 32'd0);
        resetn = 1'b0;
        #1;
        chk_reset_outputs("t6_rst");
        m_pend      = 1'b0;
        IMEM_rvalid = 1'b0;
        lat         = 1;
        tick();
        tick();
        resetn = 1'b1;
        tick();
        chk("t6_restart_req", {31'd0, IMEM_req}, 32'd1);
        chk("t6_restart_addr", IMEM_addr, 32'h0);
        expect_fetch("t6_f0", 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
